// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, fills IF/ID, applies stall/redirect/halt,
// and hands the instruction memory write port to a program loader while fetch is idle.
module fetch_controller #(
  parameter int unsigned MEM_DEPTH = 10240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        load_req,
  input  logic        load_valid,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        load_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] INS_in,
  output logic [31:0] PC_out,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [31:0] ifid_ins,
  output logic [31:0] ifid_pc1,
  output logic        ifid_valid,
  output logic        running,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  state_t      state, state_next;
  logic [31:0] pc_next, ins_next, pc1_next, count_next;
  logic        valid_next;
  logic        pc_out_of_range;

  assign pc_out_of_range = (PC_out >= DEPTH);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; loader ownership wins over start in IDLE and HALT
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load_req)   state_next = LOAD;
        else if (start) state_next = RUN;
      end
      LOAD: begin
        if (!load_req) state_next = IDLE;
      end
      RUN: begin
        if (halt_req)                          state_next = HALT;
        else if (jump || branch_taken || stall) state_next = RUN;
        else if (pc_out_of_range)              state_next = HALT;
      end
      HALT: begin
        if (load_req)   state_next = LOAD;
        else if (start) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output and datapath next-value logic
  always_comb begin
    pc_next    = PC_out;
    ins_next   = ifid_ins;
    pc1_next   = ifid_pc1;
    valid_next = 1'b0;
    count_next = fetch_count;
    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = load_addr;
    mem_wdata  = load_data;
    case (state)
      IDLE: begin
        pc_next = 32'd0;
        if (!load_req && start) count_next = 32'd0;
      end
      LOAD: begin
        load_ready = 1'b1;
        mem_we     = load_valid && (load_addr < DEPTH);
        pc_next    = 32'd0;
      end
      RUN: begin
        if (halt_req) begin
          valid_next = 1'b0;
        end else if (jump) begin
          pc_next  = jump_target;
          ins_next = 32'd0;
        end else if (branch_taken) begin
          pc_next  = branch_target;
          ins_next = 32'd0;
        end else if (stall) begin
          valid_next = ifid_valid;
        end else if (pc_out_of_range) begin
          ins_next = 32'd0;
        end else begin
          ins_next   = INS_in;
          pc1_next   = PC_out + 32'd1;
          valid_next = 1'b1;
          pc_next    = PC_out + 32'd1;
          count_next = fetch_count + 32'd1;
        end
      end
      HALT: begin
        if (load_req) begin
          pc_next = 32'd0;
        end else if (start) begin
          pc_next    = 32'd0;
          count_next = 32'd0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      PC_out      <= 32'd0;
      ifid_ins    <= 32'd0;
      ifid_pc1    <= 32'd0;
      ifid_valid  <= 1'b0;
      fetch_count <= 32'd0;
      running     <= 1'b0;
      halted      <= 1'b0;
    end else begin
      PC_out      <= pc_next;
      ifid_ins    <= ins_next;
      ifid_pc1    <= pc1_next;
      ifid_valid  <= valid_next;
      fetch_count <= count_next;
      running     <= (state_next == RUN);
      halted      <= (state_next == HALT);
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios then random traffic, all checked
// against a cycle reference model built from the fetch/load rules.
module tb_fetch_controller;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic        clk = 1'b0;
  logic        rst, start, halt_req, load_req, load_valid;
  logic [31:0] load_addr, load_data, branch_target, jump_target;
  logic        stall, branch_taken, jump;
  logic        load_ready, mem_we, ifid_valid, running, halted;
  logic [31:0] ins_in, pc_out, mem_waddr, mem_wdata, ifid_ins, ifid_pc1, fetch_count;

  logic [31:0] phys_mem [DEPTH];

  always #5 clk = ~clk;

  fetch_controller #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .load_req(load_req), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .load_ready(load_ready), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .INS_in(ins_in),
    .PC_out(pc_out), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .ifid_ins(ifid_ins), .ifid_pc1(ifid_pc1),
    .ifid_valid(ifid_valid), .running(running), .halted(halted),
    .fetch_count(fetch_count)
  );

  // Instruction memory driven by the DUT's own write port
  assign ins_in = (pc_out < DEPTH) ? phys_mem[pc_out[AW-1:0]] : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (mem_we && (mem_waddr < DEPTH)) phys_mem[mem_waddr[AW-1:0]] <= mem_wdata;
  end

  // Reference model
  typedef enum int {M_IDLE, M_LOAD, M_RUN, M_HALT} mstate_t;
  mstate_t     m_state;
  logic [31:0] m_pc, m_ins, m_pc1, m_fc;
  logic        m_valid;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] w [DEPTH];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic [31:0] fetched);
    if (rst) begin
      m_state = M_IDLE; m_pc = 0; m_ins = 0; m_pc1 = 0; m_fc = 0; m_valid = 0;
      return;
    end
    case (m_state)
      M_IDLE: begin
        m_valid = 0;
        if (load_req) begin m_state = M_LOAD; m_pc = 0; end
        else if (start) begin m_state = M_RUN; m_pc = 0; m_fc = 0; end
      end
      M_LOAD: begin
        m_valid = 0; m_pc = 0;
        if (!load_req) m_state = M_IDLE;
      end
      M_HALT: begin
        m_valid = 0;
        if (load_req) begin m_state = M_LOAD; m_pc = 0; end
        else if (start) begin m_state = M_RUN; m_pc = 0; m_fc = 0; end
      end
      default: begin
        if (halt_req) begin m_state = M_HALT; m_valid = 0; end
        else if (jump) begin m_pc = jump_target; m_valid = 0; m_ins = 0; end
        else if (branch_taken) begin m_pc = branch_target; m_valid = 0; m_ins = 0; end
        else if (stall) begin end
        else if (m_pc >= DEPTH) begin m_state = M_HALT; m_valid = 0; m_ins = 0; end
        else begin
          m_ins = fetched; m_pc1 = m_pc + 1; m_valid = 1; m_pc = m_pc + 1; m_fc = m_fc + 1;
        end
      end
    endcase
  endtask

  // One clock: check combinational loader outputs, advance model, check registers
  task automatic step();
    logic        exp_we;
    logic [31:0] fetched;
    #1;
    exp_we = (m_state == M_LOAD) && load_valid && (load_addr < DEPTH);
    check("load_ready", 32'(load_ready), 32'(m_state == M_LOAD));
    check("mem_we", 32'(mem_we), 32'(exp_we));
    if (exp_we) begin
      check("mem_waddr", mem_waddr, load_addr);
      check("mem_wdata", mem_wdata, load_data);
    end
    fetched = (m_pc < DEPTH) ? m_mem[m_pc[AW-1:0]] : 32'h0;
    if (exp_we) m_mem[load_addr[AW-1:0]] = load_data;
    model_update(fetched);
    @(posedge clk);
    #1;
    check("pc_out", pc_out, m_pc);
    check("ifid_valid", 32'(ifid_valid), 32'(m_valid));
    check("ifid_ins", ifid_ins, m_ins);
    check("ifid_pc1", ifid_pc1, m_pc1);
    check("fetch_count", fetch_count, m_fc);
    check("running", 32'(running), 32'(m_state == M_RUN));
    check("halted", 32'(halted), 32'(m_state == M_HALT));
  endtask

  task automatic clear_inputs();
    rst = 0; start = 0; halt_req = 0; load_req = 0; load_valid = 0;
    load_addr = 0; load_data = 0; stall = 0; branch_taken = 0; jump = 0;
    branch_target = 0; jump_target = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      phys_mem[i] = 0; m_mem[i] = 0; w[i] = 32'h1000_0000 + 32'(i);
    end
    w[0] = 32'h8C01_0384; w[1] = 32'h8C02_0385; w[2] = 32'h8C03_0386; w[3] = 32'h8C25_0000;
    m_state = M_IDLE; m_pc = 0; m_ins = 0; m_pc1 = 0; m_fc = 0; m_valid = 0;
    clear_inputs();
    @(posedge clk); #1;

    // Reset
    rst = 1; step(); step(); rst = 0;
    check("rst_pc", pc_out, 32'd0);
    check("rst_running", 32'(running), 32'd0);

    // Load program
    load_req = 1; step();
    for (int a = 0; a < DEPTH; a++) begin
      load_valid = 1; load_addr = 32'(a); load_data = w[a]; step();
    end
    load_valid = 0; load_req = 0; step();

    // Sequential fetch from 0
    start = 1; step(); start = 0;
    check("start_pc", pc_out, 32'd0);
    for (int j = 1; j <= 4; j++) begin
      step();
      check("seq_ins", ifid_ins, w[j-1]);
      check("seq_pc1", ifid_pc1, 32'(j));
    end
    check("seq_count", fetch_count, 32'd4);

    // Jump at PC 12 to 5
    for (int i = 0; i < 20 && pc_out != 32'd12; i++) step();
    check("reach_pc12", pc_out, 32'd12);
    jump = 1; jump_target = 32'd5; step(); jump = 0;
    check("jump_pc", pc_out, 32'd5);
    check("jump_bubble", 32'(ifid_valid), 32'd0);
    step();
    check("jump_ins", ifid_ins, w[5]);
    check("jump_valid", 32'(ifid_valid), 32'd1);

    // Stall at PC 7, branch to 0x15 on third stall cycle
    for (int i = 0; i < 4 && pc_out != 32'd7; i++) step();
    check("reach_pc7", pc_out, 32'd7);
    stall = 1; step(); check("stall1_pc", pc_out, 32'd7);
    step(); check("stall2_pc", pc_out, 32'd7);
    branch_taken = 1; branch_target = 32'h15; step();
    stall = 0; branch_taken = 0;
    check("branch_pc", pc_out, 32'h15);
    check("branch_flush", 32'(ifid_valid), 32'd0);
    step();
    check("oor_halt", 32'(halted), 32'd1);

    // Load from HALT: addr 3 written, addr 20 suppressed
    load_req = 1; step();
    check("load_pc0", pc_out, 32'd0);
    load_valid = 1; load_addr = 32'd3; load_data = 32'hA5A5_0003; #1;
    check("we_in_range", 32'(mem_we), 32'd1);
    step();
    w[3] = 32'hA5A5_0003;
    load_addr = 32'd20; load_data = 32'h5A5A_0014; #1;
    check("we_out_range", 32'(mem_we), 32'd0);
    step();
    load_valid = 0; load_req = 0; step();
    start = 1; step(); start = 0;
    check("restart_pc", pc_out, 32'd0);
    for (int i = 0; i < 40 && !halted; i++) step();
    check("run_halted", 32'(halted), 32'd1);
    check("run_count", fetch_count, 32'd16);
    check("run_pc", pc_out, 32'd16);
    check("run_valid", 32'(ifid_valid), 32'd0);

    // Reset in the middle of a LOAD write
    load_req = 1; step();
    load_valid = 1; load_addr = 32'd2; load_data = 32'h0BAD_0002; rst = 1; step();
    rst = 0; #1;
    check("rst_load_we", 32'(mem_we), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_load_count", fetch_count, 32'd0);
    step();
    load_valid = 0; load_req = 0; step();

    // Random traffic
    clear_inputs();
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 63) == 0);
      start        = ($urandom_range(0, 7) == 0);
      halt_req     = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 15) == 0) load_req = ~load_req;
      load_valid   = $urandom_range(0, 1) == 1;
      load_addr    = 32'($urandom_range(0, 31));
      load_data    = $urandom;
      stall        = ($urandom_range(0, 4) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      jump         = ($urandom_range(0, 15) == 0);
      branch_target = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 20));
      jump_target   = 32'($urandom_range(0, 20));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
